// File: rtl/keypad_pkg.sv
// keypad_pkg
//   Shared types and constants for the 4x4 keypad scanner.
//   - state_t    : debounce FSM states
//   - scan_res_t : classification of one complete four-column scan
//   - KEY_W/NCOL : key code width and number of driven columns
//   - count_low / low_index : helpers for decoding one column's active-low rows
`timescale 1ns/1ps
package keypad_pkg;
  localparam int KEY_W = 4;
  localparam int NCOL  = 4;

  typedef enum logic [1:0] {IDLE, CONFIRM, PRESSED, RELEASE} state_t;
  typedef enum logic [1:0] {NONE, SINGLE, MULTI} scan_res_t;

  // Number of asserted bits in a 4-bit row mask (0..4).
  function automatic logic [2:0] count_low(input logic [3:0] low);
    count_low = 3'(low[0]) + 3'(low[1]) + 3'(low[2]) + 3'(low[3]);
  endfunction

  // Index of the lowest asserted bit; only meaningful when exactly one is set.
  function automatic logic [1:0] low_index(input logic [3:0] low);
    low_index = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (low[i]) low_index = 2'(i);
    end
  endfunction
endpackage

// File: rtl/keypad_row_sync.sv
// keypad_row_sync
//   Two-flop synchronizer for the asynchronous keypad row inputs.
//   Flops reset to 1 so an idle (pulled-up) keypad reads as "no key".
//   Ports:
//     i_clk     : system clock
//     i_reset_n : synchronous active-low reset
//     i_d       : asynchronous input bus
//     o_q       : synchronized output bus
`timescale 1ns/1ps
module keypad_row_sync #(
  parameter int W = 4
) (
  input  logic         i_clk,
  input  logic         i_reset_n,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);
  logic [W-1:0] r_meta;
  logic [W-1:0] r_sync;

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_meta <= '1;
      r_sync <= '1;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;
endmodule

// File: rtl/keypad_scan_reader.sv
// keypad_scan_reader
//   Scans a 4x4 active-low matrix keypad one column at a time, debounces
//   complete scans and presents accepted keys with a valid/ack handshake.
//   Ports:
//     i_clk       : system clock
//     i_reset_n   : synchronous active-low reset
//     i_row_in    : keypad rows, active low, asynchronous
//     o_col_out   : column drive, active low, one bit low at a time
//     o_key_code  : last accepted key, row*4 + col
//     o_key_valid : new key pending until acknowledged
//     i_key_ack   : consumer acknowledge
//     o_key_down  : debounced "key held" level
//     o_overrun   : sticky, a key was accepted while one was still pending
`timescale 1ns/1ps
module keypad_scan_reader
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 50000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic [3:0]       i_row_in,
  output logic [NCOL-1:0]  o_col_out,
  output logic [KEY_W-1:0] o_key_code,
  output logic             o_key_valid,
  input  logic             i_key_ack,
  output logic             o_key_down,
  output logic             o_overrun
);
  localparam int DW_W  = (SCAN_DIV < 2) ? 1 : $clog2(SCAN_DIV);
  // The counter only has to reach DEBOUNCE_SCANS-1: the matching scan that
  // would make it DEBOUNCE_SCANS triggers the transition directly.
  localparam int CNT_W = (DEBOUNCE_SCANS < 2) ? 1 : $clog2(DEBOUNCE_SCANS);
  localparam logic [DW_W-1:0]  DWELL_LAST = DW_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(DEBOUNCE_SCANS - 1);
  localparam logic [1:0]       COL_LAST   = 2'(NCOL - 1);

  logic [DW_W-1:0]  r_dwell;
  logic [1:0]       r_col;
  logic [NCOL-1:0]  r_col_out;
  logic [1:0]       r_hits;       // low pairs seen so far this scan, saturates at 2
  logic [KEY_W-1:0] r_hit_code;
  state_t           r_state;
  logic [CNT_W-1:0] r_count;
  logic [KEY_W-1:0] r_cand;
  logic [KEY_W-1:0] r_key_code;
  logic             r_key_valid;
  logic             r_key_down;
  logic             r_overrun;

  logic [3:0]       w_row_sync;
  logic [3:0]       w_low;
  logic [2:0]       w_col_hits;
  logic [2:0]       w_total;
  logic [KEY_W-1:0] w_code;
  logic [1:0]       w_col_next;
  logic             w_dwell_last;
  logic             w_scan_done;
  logic             w_accept;
  scan_res_t        w_res;

  keypad_row_sync #(.W(4)) u_row_sync (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_d       (i_row_in),
    .o_q       (w_row_sync)
  );

  assign w_low        = ~w_row_sync;
  assign w_col_hits   = count_low(w_low);
  assign w_total      = {1'b0, r_hits} + w_col_hits;
  // Earlier columns hold the code if they already saw a hit; if they saw
  // none, the current column supplies it.
  assign w_code       = (r_hits != 2'd0) ? r_hit_code : {low_index(w_low), r_col};
  assign w_col_next   = r_col + 2'd1;
  assign w_dwell_last = (r_dwell == DWELL_LAST);
  assign w_scan_done  = w_dwell_last && (r_col == COL_LAST);

  // Result of the scan completing this cycle (valid only with w_scan_done).
  always_comb begin
    w_res = NONE;
    if (w_total == 3'd1)      w_res = SINGLE;
    else if (w_total >= 3'd2) w_res = MULTI;
  end

  always_comb begin
    w_accept = 1'b0;
    if (w_scan_done && (w_res == SINGLE)) begin
      case (r_state)
        IDLE:    w_accept = (DEBOUNCE_SCANS == 1);
        CONFIRM: w_accept = (w_code == r_cand) && (r_count == CNT_LAST);
        default: w_accept = 1'b0;
      endcase
    end
  end

  // Column scan timer and per-scan hit accumulator.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_dwell    <= '0;
      r_col      <= 2'd0;
      r_col_out  <= 4'b1110;
      r_hits     <= 2'd0;
      r_hit_code <= '0;
    end else if (w_dwell_last) begin
      r_dwell    <= '0;
      r_col      <= w_col_next;
      r_col_out  <= ~(4'b0001 << w_col_next);
      r_hit_code <= w_code;
      if (r_col == COL_LAST) r_hits <= 2'd0;
      else                   r_hits <= (w_total >= 3'd2) ? 2'd2 : w_total[1:0];
    end else begin
      r_dwell <= r_dwell + DW_W'(1);
    end
  end

  // Debounce FSM and consumer handshake.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_state     <= IDLE;
      r_count     <= '0;
      r_cand      <= '0;
      r_key_code  <= '0;
      r_key_valid <= 1'b0;
      r_key_down  <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_key_down <= 1'b1;
        // A pending, unacknowledged key is kept; the new one is dropped.
        if (r_key_valid && !i_key_ack) begin
          r_overrun <= 1'b1;
        end else begin
          r_key_code  <= w_code;
          r_key_valid <= 1'b1;
        end
      end else if (r_key_valid && i_key_ack) begin
        r_key_valid <= 1'b0;
      end

      if (w_scan_done) begin
        case (r_state)
          IDLE: begin
            if (w_res == SINGLE) begin
              r_cand  <= w_code;
              r_count <= CNT_W'(1);
              r_state <= (DEBOUNCE_SCANS == 1) ? PRESSED : CONFIRM;
            end
          end
          CONFIRM: begin
            if ((w_res == SINGLE) && (w_code == r_cand)) begin
              if (r_count == CNT_LAST) r_state <= PRESSED;
              else                     r_count <= r_count + CNT_W'(1);
            end else begin
              r_state <= IDLE;
            end
          end
          PRESSED: begin
            if (w_res == NONE) begin
              r_count <= CNT_W'(1);
              if (DEBOUNCE_SCANS == 1) begin
                r_state    <= IDLE;
                r_key_down <= 1'b0;
              end else begin
                r_state <= RELEASE;
              end
            end
          end
          RELEASE: begin
            if (w_res != NONE) begin
              r_state <= PRESSED;
            end else if (r_count == CNT_LAST) begin
              r_state    <= IDLE;
              r_key_down <= 1'b0;
            end else begin
              r_count <= r_count + CNT_W'(1);
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign o_col_out   = r_col_out;
  assign o_key_code  = r_key_code;
  assign o_key_valid = r_key_valid;
  assign o_key_down  = r_key_down;
  assign o_overrun   = r_overrun;
endmodule

// File: tb/tb_keypad_scan_reader.sv
`timescale 1ns/1ps
module tb_keypad_scan_reader;
  localparam int SCAN_DIV = 4;
  localparam int DB       = 2;
  localparam int SCAN     = 4 * SCAN_DIV;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] row_in;
  logic [3:0] col_out;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_ack;
  logic       key_down;
  logic       overrun;
  logic [15:0] pressed;   // bit r*4+c = key at row r, column c held

  int n_checks = 0;
  int n_pass   = 0;
  logic [3:0] sb[$];      // expected accepted key codes, in order

  always #5 clk = ~clk;

  keypad_scan_reader #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_SCANS(DB)) dut (
    .i_clk       (clk),
    .i_reset_n   (rst_n),
    .i_row_in    (row_in),
    .o_col_out   (col_out),
    .o_key_code  (key_code),
    .o_key_valid (key_valid),
    .i_key_ack   (key_ack),
    .o_key_down  (key_down),
    .o_overrun   (overrun)
  );

  // Keypad matrix model: a held key pulls its row low while its column is driven.
  always_comb begin
    row_in = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !col_out[c]) row_in[r] = 1'b0;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_col"},   32'(col_out),   32'hE);
    check({tag, "_code"},  32'(key_code),  32'h0);
    check({tag, "_valid"}, 32'(key_valid), 32'h0);
    check({tag, "_down"},  32'(key_down),  32'h0);
    check({tag, "_ovr"},   32'(overrun),   32'h0);
  endtask

  // Ends on the negedge where reset is released: scan-aligned point.
  task automatic do_reset(input string tag);
    rst_n = 1'b0; key_ack = 1'b0; pressed = '0;
    repeat (3) @(negedge clk);
    check_reset_vals(tag);
    rst_n = 1'b1;
  endtask

  // Scoreboard monitor: each new key_valid event pops one expected code.
  logic       prev_valid = 1'b0;
  logic [3:0] prev_code  = 4'd0;
  always @(negedge clk) begin
    if (rst_n && key_valid && (!prev_valid || key_code != prev_code)) begin
      if (sb.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_event: got code %0d expected no event", key_code);
      end else begin
        logic [3:0] e;
        e = sb.pop_front();
        check("event_code", 32'(key_code), 32'(e));
        $display("event: key_code=%0d", key_code);
      end
    end
    prev_valid = key_valid;
    prev_code  = key_code;
  end

  typedef struct {
    logic [15:0] keys;
    int          scans;
    bit          ack_last;  // ack during the final cycle of the step
    bit          ev;        // step is expected to produce a new key event
    logic [3:0]  e_code;
    bit          e_valid;
    bit          e_down;
    bit          e_ovr;
    string       name;
  } vec_t;

  vec_t tbl[$];

  task automatic add_vec(input logic [15:0] keys, input int scans, input bit ack_last,
                         input bit ev, input logic [3:0] code, input bit v, input bit d,
                         input bit o, input string name);
    vec_t t;
    t.keys = keys; t.scans = scans; t.ack_last = ack_last; t.ev = ev;
    t.e_code = code; t.e_valid = v; t.e_down = d; t.e_ovr = o; t.name = name;
    tbl.push_back(t);
  endtask

  // Starts and ends on a scan boundary.
  task automatic run_vec(input vec_t t);
    if (t.ev) sb.push_back(t.e_code);
    pressed = t.keys;
    repeat (SCAN * t.scans - 1) @(negedge clk);
    key_ack = t.ack_last;
    @(negedge clk);
    key_ack = 1'b0;
    $display("vec %s: valid=%0d code=%0d down=%0d ovr=%0d",
             t.name, key_valid, key_code, key_down, overrun);
    check({t.name, "_valid"}, 32'(key_valid), 32'(t.e_valid));
    check({t.name, "_code"},  32'(key_code),  32'(t.e_code));
    check({t.name, "_down"},  32'(key_down),  32'(t.e_down));
    check({t.name, "_ovr"},   32'(overrun),   32'(t.e_ovr));
  endtask

  task automatic run_range(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) run_vec(tbl[i]);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    //       keys      scans ack ev code v d o  name
    add_vec(16'h0200, 1, 0, 0, 4'd0,  0, 0, 0, "k9_scan1");      // 0
    add_vec(16'h0200, 1, 0, 1, 4'd9,  1, 1, 0, "k9_accept");     // 1
    add_vec(16'h0200, 1, 0, 0, 4'd9,  1, 1, 0, "k9_held");       // 2
    add_vec(16'h0000, 1, 0, 0, 4'd9,  0, 1, 0, "k9_rel1");       // 3
    add_vec(16'h0000, 1, 0, 0, 4'd9,  0, 0, 0, "k9_rel2");       // 4
    add_vec(16'h0200, 1, 0, 0, 4'd9,  0, 0, 0, "bounce_on1");    // 5
    add_vec(16'h0000, 1, 0, 0, 4'd9,  0, 0, 0, "bounce_off");    // 6
    add_vec(16'h0200, 1, 0, 0, 4'd9,  0, 0, 0, "bounce_on2");    // 7
    add_vec(16'h0000, 1, 0, 0, 4'd9,  0, 0, 0, "bounce_end");    // 8
    add_vec(16'h0021, 3, 0, 0, 4'd9,  0, 0, 0, "multi_0_5");     // 9
    add_vec(16'h0020, 2, 0, 1, 4'd5,  1, 1, 0, "k5_accept");     // 10
    add_vec(16'h0000, 2, 0, 0, 4'd5,  1, 0, 0, "k5_release");    // 11
    add_vec(16'h1000, 2, 0, 0, 4'd5,  1, 1, 1, "k12_overrun");   // 12
    add_vec(16'h0020, 2, 0, 1, 4'd5,  1, 1, 0, "k5_again");      // 13
    add_vec(16'h0000, 2, 0, 0, 4'd5,  1, 0, 0, "k5_rel_again");  // 14
    add_vec(16'h1000, 1, 0, 0, 4'd5,  1, 0, 0, "k12_confirm");   // 15
    add_vec(16'h1000, 1, 1, 1, 4'd12, 1, 1, 0, "k12_ack_same");  // 16
    add_vec(16'h0000, 2, 0, 0, 4'd12, 1, 0, 0, "k12_release");   // 17
    add_vec(16'h0001, 1, 0, 0, 4'd12, 1, 0, 0, "k0_confirm");    // 18
    add_vec(16'h0001, 1, 0, 0, 4'd0,  0, 0, 0, "k0_after_rst");  // 19

    rst_n = 1'b0; key_ack = 1'b0; pressed = '0;
    do_reset("rst");

    // Column walk from reset release: each column held for SCAN_DIV cycles.
    for (int k = 0; k < SCAN; k++) begin
      logic [3:0] one;
      one = 4'b0001;
      check($sformatf("walk%0d_col", k), 32'(col_out), 32'(~(one << (k / SCAN_DIV)) & 4'hF));
      @(negedge clk);
    end
    check("walk_valid", 32'(key_valid), 32'h0);
    check("walk_down",  32'(key_down),  32'h0);

    run_range(0, 2);

    // Ack while valid: clears on the following cycle.
    key_ack = 1'b1;
    @(negedge clk);
    key_ack = 1'b0;
    check("ack_clears_valid", 32'(key_valid), 32'h0);
    check("ack_keeps_down",   32'(key_down),  32'h1);
    $display("ack: valid=%0d", key_valid);
    repeat (SCAN - 1) @(negedge clk);

    run_range(3, 9);

    do_reset("rst2");
    run_range(10, 12);

    do_reset("rst3");
    run_range(13, 18);

    // Reset in the middle of a scan while CONFIRM holds key 0.
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_vals("midrst");
    $display("mid-scan reset: col=%b valid=%0d", col_out, key_valid);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    // A single scan must not accept: the FSM restarted from IDLE.
    run_range(19, 19);

    check("sb_empty", 32'(sb.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/keypad_scan_reader.md
# keypad_scan_reader

Scans a 4x4 matrix keypad and delivers debounced key codes to the CPU/board logic. It is the input-side counterpart of the multiplexed seven-segment display path: the display time-multiplexes digit enables outward, and this block time-multiplexes column drives outward and reads rows back. It runs on the board clock and presents each new keypress as a held valid/acknowledge event.

## Interface
- SCAN_DIV, 50000: clock cycles each column is driven (dwell); must be >= 4.
- DEBOUNCE_SCANS, 4: consecutive identical full scans required to accept a press or a release; must be >= 1.
- Clk  input  1  system clock; all logic rises on it.
- Reset  input  1  synchronous, active-low reset.
- row_in  input  4  keypad rows, active-low (pulled up), asynchronous to Clk.
- col_out  output  4  column drive, active-low, exactly one bit low at all times.
- key_code  output  4  code of last accepted key = row*4 + col.
- key_valid  output  1  new key pending; held until acknowledged.
- key_ack  input  1  consumer acknowledge, sampled while key_valid=1.
- key_down  output  1  debounced "a key is held" level.
- overrun  output  1  sticky: a press was accepted while key_valid was still pending.

## Operation
- row_in passes through a 2-flop synchronizer before use.
- Scan timer: dwell counter 0..SCAN_DIV-1, column index 0..3. On the last dwell cycle, the synchronized rows are sampled for the current column, then the column advances (3 wraps to 0) and col_out updates the next cycle.
- Scan result, formed after column 3 is sampled: NONE (no low row anywhere), SINGLE(code) (exactly one low row/column pair), MULTI (two or more).
- FSM states:
  - IDLE: SINGLE goes to CONFIRM with candidate=code, count=1. NONE or MULTI stay in IDLE.
  - CONFIRM: SINGLE with the same code increments count. Reaching DEBOUNCE_SCANS accepts the press and goes to PRESSED. Any other result goes to IDLE.
  - PRESSED: NONE goes to RELEASE with count=1. SINGLE or MULTI (any code) stay in PRESSED.
  - RELEASE: NONE increments count. Reaching DEBOUNCE_SCANS goes to IDLE. Any non-NONE result goes back to PRESSED. No new event is produced.
- With DEBOUNCE_SCANS=1, acceptance happens directly from IDLE on the first SINGLE scan.
- Accept event: key_code<=candidate, key_valid<=1, key_down<=1. If key_valid is already 1 and key_ack is 0 in that cycle, key_code is NOT updated (old key retained) and overrun<=1.
- key_down clears on entry to IDLE from RELEASE.
- Handshake: key_ack=1 while key_valid=1 clears key_valid next cycle. key_ack with key_valid=0 is ignored. Ack and accept in the same cycle: the accept wins, key_valid stays 1, key_code takes the new code, overrun is unchanged.

## Timing
- Reset values: col_out=4'b1110, key_code=0, key_valid=0, key_down=0, overrun=0, state IDLE, counters 0, synchronizer flops 1.
- Full scan period = 4*SCAN_DIV cycles. Minimum press latency from a stable row level to key_valid is at most DEBOUNCE_SCANS+1 scan periods plus 3 cycles.
- key_valid and key_down rise 1 cycle after the column-3 sample of the accepting scan.
- Reset mid-operation: everything returns to reset values on the next edge. A pending key is lost and overrun clears.
- overrun clears only on Reset.

## Structure
- Package keypad_pkg: state enum (IDLE, CONFIRM, PRESSED, RELEASE), scan-result enum (NONE, SINGLE, MULTI), and KEY_W=4 and NCOL=4 constants.
- Sub-module keypad_row_sync: parameterised-width 2-flop synchronizer with reset value 1.
- Scan timer, result encoder, FSM and handshake live in keypad_scan_reader.

## Test plan
All scenarios use SCAN_DIV=4 and DEBOUNCE_SCANS=2, so one scan is 16 cycles.
- Reset release -> col_out walks 1110, 1101, 1011, 0111, changing every 4 cycles; all other outputs stay 0.
- Hold row 2 low while column 1 is driven, for 3 scans -> key_valid=1 with key_code=9 after the 2nd matching scan; key_down=1.
- Bounce: key 9 present for 1 scan, absent 1 scan, present 1 scan -> no key_valid.
- Pulse key_ack with key_valid=1 -> key_valid=0 next cycle. Release the key for 2 scans -> key_down=0.
- Press 5, no ack, release, then press 12 -> key_code stays 5 and overrun=1. Ack on the same cycle as the accept of 12 -> key_code=12, key_valid=1, overrun=0.
- Keys 0 and 5 pressed together -> MULTI, no event. Assert Reset during CONFIRM -> all outputs return to reset values next edge.
